// File: rtl/key_debounce_pkg.sv
// Shared types and defaults for the push-button debouncer.
// State encoding is binary; one-hot buys nothing for four states.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLT_DN = 2'd1,
    ST_DOWN   = 2'd2,
    ST_FLT_UP = 2'd3
  } key_st_e;

  localparam int          KEY_NUM_DEF = 4;
  localparam int          CNT_W_DEF   = 20;
  // 20 ms at 50 MHz, minus one
  localparam int unsigned CNT_MAX_DEF = 999_999;

endpackage

// File: rtl/key_filter_ch.sv
// One key channel: 2-flop synchronizer, filter FSM and stability counter.
// Input is active-low; outputs are active-high and fully registered.
module key_filter_ch
  import key_debounce_pkg::*;
#(
  parameter int          CNT_W   = CNT_W_DEF,
  parameter int unsigned CNT_MAX = CNT_MAX_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_in,
  output logic key_state,
  output logic key_flag,
  output logic key_release
);

  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);

  logic [1:0]       r_sync;
  logic             w_ks;
  key_st_e          r_st;
  key_st_e          w_st_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_state;
  logic             w_state_nxt;
  logic             r_flag;
  logic             w_flag_nxt;
  logic             r_rel;
  logic             w_rel_nxt;

  // Flops reset to 1 so a held key looks released until sampled
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_sync <= 2'b11;
    else         r_sync <= {r_sync[0], key_in};
  end

  assign w_ks = r_sync[1];

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_st    <= ST_IDLE;
      r_cnt   <= '0;
      r_state <= 1'b0;
      r_flag  <= 1'b0;
      r_rel   <= 1'b0;
    end else begin
      r_st    <= w_st_nxt;
      r_cnt   <= w_cnt_nxt;
      r_state <= w_state_nxt;
      r_flag  <= w_flag_nxt;
      r_rel   <= w_rel_nxt;
    end
  end

  always_comb begin
    w_st_nxt    = r_st;
    w_cnt_nxt   = r_cnt;
    w_state_nxt = r_state;
    w_flag_nxt  = 1'b0;
    w_rel_nxt   = 1'b0;
    unique case (r_st)
      ST_IDLE: begin
        if (!w_ks) begin
          w_st_nxt  = ST_FLT_DN;
          w_cnt_nxt = '0;
        end
      end
      ST_FLT_DN: begin
        if (w_ks) begin
          w_st_nxt  = ST_IDLE;
          w_cnt_nxt = '0;
        end else if (r_cnt == LP_MAX) begin
          w_st_nxt    = ST_DOWN;
          w_cnt_nxt   = '0;
          w_flag_nxt  = 1'b1;
          w_state_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + LP_ONE;
        end
      end
      ST_DOWN: begin
        if (w_ks) begin
          w_st_nxt  = ST_FLT_UP;
          w_cnt_nxt = '0;
        end
      end
      ST_FLT_UP: begin
        if (!w_ks) begin
          w_st_nxt  = ST_DOWN;
          w_cnt_nxt = '0;
        end else if (r_cnt == LP_MAX) begin
          w_st_nxt    = ST_IDLE;
          w_cnt_nxt   = '0;
          w_rel_nxt   = 1'b1;
          w_state_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + LP_ONE;
        end
      end
    endcase
  end

  assign key_state   = r_state;
  assign key_flag    = r_flag;
  assign key_release = r_rel;

endmodule

// File: rtl/key_debounce.sv
// Multi-key debouncer: KEY_NUM independent filter channels side by side.
// Reset deassertion is assumed already synchronized upstream.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int          KEY_NUM = KEY_NUM_DEF,
  parameter int unsigned CNT_MAX = CNT_MAX_DEF,
  parameter int          CNT_W   = CNT_W_DEF
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] key_flag,
  output logic [KEY_NUM-1:0] key_release
);

  for (genvar g = 0; g < KEY_NUM; g++) begin : g_ch
    key_filter_ch #(
      .CNT_W   (CNT_W),
      .CNT_MAX (CNT_MAX)
    ) u_ch (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .key_in      (key_in[g]),
      .key_state   (key_state[g]),
      .key_flag    (key_flag[g]),
      .key_release (key_release[g])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: expected pulses are queued with their cycle
// when keys are driven, and matched by a monitor as the DUT pulses.
module tb_key_debounce;

  localparam int KN  = 4;
  localparam int LAT = 13;

  typedef struct {
    int       cyc;
    logic [3:0] flag;
    logic [3:0] rel;
  } ev_t;

  logic          sys_clk;
  logic          sys_rst;
  logic [KN-1:0] key_in;
  logic [KN-1:0] key_state;
  logic [KN-1:0] key_flag;
  logic [KN-1:0] key_release;

  int  cyc   = 0;
  int  tests = 0;
  int  fails = 0;
  ev_t exp_q[$];

  key_debounce #(
    .KEY_NUM (KN),
    .CNT_MAX (9),
    .CNT_W   (4)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .key_in      (key_in),
    .key_state   (key_state),
    .key_flag    (key_flag),
    .key_release (key_release)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin : monitor
    ev_t e;
    forever begin
      @(posedge sys_clk);
      cyc++;
      #1;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        tests++;
        fails++;
        $display("FAIL missed_pulse cyc=%0d: saw none, required flag=%b rel=%b",
                 exp_q[0].cyc, exp_q[0].flag, exp_q[0].rel);
        void'(exp_q.pop_front());
      end
      if (key_flag !== 4'b0 || key_release !== 4'b0) begin
        tests++;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
          e = exp_q.pop_front();
          if (key_flag !== e.flag || key_release !== e.rel) begin
            fails++;
            $display("FAIL pulse cyc=%0d: got flag=%b rel=%b, required flag=%b rel=%b",
                     cyc, key_flag, key_release, e.flag, e.rel);
          end
        end else begin
          fails++;
          $display("FAIL unexpected_pulse cyc=%0d: got flag=%b rel=%b, required none",
                   cyc, key_flag, key_release);
        end
      end
    end
  end

  task automatic test_reset;
    sys_rst = 1'b1;
    key_in  = 4'hF;
    repeat (3) @(posedge sys_clk);
    #1;
    tests++;
    if (key_state !== 4'b0 || key_flag !== 4'b0 || key_release !== 4'b0) begin
      fails++;
      $display("FAIL reset_outputs: got state=%b flag=%b rel=%b, required all 0",
               key_state, key_flag, key_release);
    end
    @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (50) @(posedge sys_clk);
    #2;
    tests++;
    if (key_state !== 4'b0) begin
      fails++;
      $display("FAIL idle_after_reset: got state=%b, required 0000", key_state);
    end
  endtask

  task automatic test_clean_press;
    @(negedge sys_clk);
    key_in[0] = 1'b0;
    exp_q.push_back('{cyc + LAT, 4'b0001, 4'b0000});
    repeat (LAT - 1) @(posedge sys_clk);
    #2;
    tests++;
    if (key_state !== 4'b0000) begin
      fails++;
      $display("FAIL press_early edge12: got state=%b, required 0000", key_state);
    end
    @(posedge sys_clk);
    #2;
    tests++;
    if (key_state !== 4'b0001) begin
      fails++;
      $display("FAIL press_state edge13: got state=%b, required 0001", key_state);
    end
    repeat (10) @(negedge sys_clk);
    key_in[0] = 1'b1;
    exp_q.push_back('{cyc + LAT, 4'b0000, 4'b0001});
    repeat (LAT - 1) @(posedge sys_clk);
    #2;
    tests++;
    if (key_state !== 4'b0001) begin
      fails++;
      $display("FAIL release_early edge12: got state=%b, required 0001", key_state);
    end
    @(posedge sys_clk);
    #2;
    tests++;
    if (key_state !== 4'b0000) begin
      fails++;
      $display("FAIL release_state edge13: got state=%b, required 0000", key_state);
    end
  endtask

  task automatic test_bounce;
    @(negedge sys_clk);
    repeat (5) begin
      key_in[1] = 1'b0;
      repeat (4) @(negedge sys_clk);
      key_in[1] = 1'b1;
      repeat (4) @(negedge sys_clk);
    end
    repeat (20) @(negedge sys_clk);
    tests++;
    if (key_state !== 4'b0000) begin
      fails++;
      $display("FAIL bounce_state: got state=%b, required 0000", key_state);
    end
    key_in[1] = 1'b0;
    exp_q.push_back('{cyc + LAT, 4'b0010, 4'b0000});
    repeat (20) @(negedge sys_clk);
    tests++;
    if (key_state !== 4'b0010) begin
      fails++;
      $display("FAIL bounce_then_hold: got state=%b, required 0010", key_state);
    end
    key_in[1] = 1'b1;
    exp_q.push_back('{cyc + LAT, 4'b0000, 4'b0010});
    repeat (20) @(negedge sys_clk);
  endtask

  task automatic test_release_bounce;
    key_in[2] = 1'b0;
    exp_q.push_back('{cyc + LAT, 4'b0100, 4'b0000});
    repeat (20) @(negedge sys_clk);
    key_in[2] = 1'b1;
    repeat (5) @(negedge sys_clk);
    key_in[2] = 1'b0;
    repeat (20) @(negedge sys_clk);
    tests++;
    if (key_state !== 4'b0100) begin
      fails++;
      $display("FAIL release_bounce_state: got state=%b, required 0100", key_state);
    end
    key_in[2] = 1'b1;
    exp_q.push_back('{cyc + LAT, 4'b0000, 4'b0100});
    repeat (20) @(negedge sys_clk);
  endtask

  task automatic test_simultaneous;
    key_in = 4'h0;
    exp_q.push_back('{cyc + LAT, 4'b1111, 4'b0000});
    repeat (20) @(negedge sys_clk);
    tests++;
    if (key_state !== 4'b1111) begin
      fails++;
      $display("FAIL simul_state: got state=%b, required 1111", key_state);
    end
    key_in = 4'hF;
    exp_q.push_back('{cyc + LAT, 4'b0000, 4'b1111});
    repeat (20) @(negedge sys_clk);
    tests++;
    if (key_state !== 4'b0000) begin
      fails++;
      $display("FAIL simul_release: got state=%b, required 0000", key_state);
    end
  endtask

  task automatic test_reset_mid;
    key_in[3] = 1'b0;
    repeat (6) @(negedge sys_clk);
    sys_rst = 1'b1;
    #1;
    tests++;
    if (key_state !== 4'b0 || key_flag !== 4'b0 || key_release !== 4'b0) begin
      fails++;
      $display("FAIL rst_in_flt_dn: got state=%b flag=%b rel=%b, required all 0",
               key_state, key_flag, key_release);
    end
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    exp_q.push_back('{cyc + LAT, 4'b1000, 4'b0000});
    repeat (15) @(negedge sys_clk);
    tests++;
    if (key_state !== 4'b1000) begin
      fails++;
      $display("FAIL held_after_rst: got state=%b, required 1000", key_state);
    end
    sys_rst = 1'b1;
    #1;
    tests++;
    if (key_state !== 4'b0 || key_flag !== 4'b0 || key_release !== 4'b0) begin
      fails++;
      $display("FAIL rst_in_down: got state=%b flag=%b rel=%b, required all 0",
               key_state, key_flag, key_release);
    end
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    exp_q.push_back('{cyc + LAT, 4'b1000, 4'b0000});
    repeat (15) @(negedge sys_clk);
    tests++;
    if (key_state !== 4'b1000) begin
      fails++;
      $display("FAIL redetect_after_rst: got state=%b, required 1000", key_state);
    end
    key_in[3] = 1'b1;
    exp_q.push_back('{cyc + LAT, 4'b0000, 4'b1000});
    repeat (20) @(negedge sys_clk);
  endtask

  initial begin
    sys_rst = 1'b1;
    key_in  = 4'hF;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_simultaneous();
    test_reset_mid();
    repeat (20) @(negedge sys_clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pending_events: got %0d left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
